// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared operation codes and FSM state encoding for the iterative
//            shift unit.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam logic [1:0] SHIFT_SRL  = 2'b00;
    localparam logic [1:0] SHIFT_SLL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single-step shifter applied once per SHIFT cycle.
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] acc,
    input  logic [4:0]      k,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] shifted
);

    always_comb begin
        shifted = acc;
        case (op)
            SHIFT_SRL: shifted = acc >> k;
            SHIFT_SLL: shifted = acc << k;
            // Sign bit is preserved by every arithmetic step, so acc[MSB] == a[MSB].
            SHIFT_SRA: shifted = $signed(acc) >>> k;
            default:   shifted = acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/iterative_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : iterative_shift_unit
// Purpose  : Multi-cycle SRL/SLL/SRA unit shifting at most STEP bits per clock,
//            with valid/ready handshakes on request and result sides.
// Revision : 1.0 - initial release
// ============================================================================
module iterative_shift_unit
    import shift_pkg::*;
#(
    parameter int STEP = 1,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [4:0]      shamt,
    input  logic [1:0]      op_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] r,
    output logic            busy
);

    // cnt never exceeds 31, so min(cnt, 32) == min(cnt, 31) and the step fits 5 bits.
    localparam logic [4:0] STEP_CAP = 5'((STEP > 31) ? 31 : STEP);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [4:0]        k;
    logic [4:0]        cnt_rem;
    logic [XLEN-1:0]   step_out;

    assign k       = (cnt_q < STEP_CAP) ? cnt_q : STEP_CAP;
    assign cnt_rem = cnt_q - k;

    shift_step #(
        .XLEN (XLEN)
    ) u_shift_step (
        .acc     (acc_q),
        .k       (k),
        .op      (op_q),
        .shifted (step_out)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = a;
                    cnt_d   = shamt;
                    op_d    = op_type;
                    state_d = (shamt == 5'd0 || op_type == SHIFT_PASS) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d = step_out;
                cnt_d = cnt_rem;
                if (cnt_rem == 5'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= SHIFT_SRL;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign r         = acc_q;

endmodule
`default_nettype wire
